// File: rtl/ad936x_pkg.sv
// Types and constants shared by the AD936x data interface, RX sample FIFO and TX path.
// The I/Q pair travels as one struct so the two halves cannot be split or swapped.
package ad936x_pkg;

  localparam int SAMPLE_W = 12;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_sample_t;

  // Width of a level counter that must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ad936x_rx_sample_fifo_if.sv
// Bus between the AD936x RX port, the RX sample FIFO and its consumer.
// The FIFO sits on the slave modport; the bench or surrounding logic drives the master modport.
interface ad936x_rx_sample_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
);
  import ad936x_pkg::*;

  localparam int LVL_W = level_width(DEPTH);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both high. in_valid may be offered at any time. Once out_valid is high,
  // out_i/out_q hold steady until the cycle where out_ready is also high.
  logic [SAMPLE_W-1:0] in_i;
  logic [SAMPLE_W-1:0] in_q;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] out_i;
  logic [SAMPLE_W-1:0] out_q;
  logic                out_valid;
  logic                out_ready;
  logic [LVL_W-1:0]    level;
  logic                almost_full;
  logic                overflow;
  logic [CNT_W-1:0]    drop_count;
  logic                clear_overflow;

  modport slave (
    input  in_i, in_q, in_valid, out_ready, clear_overflow,
    output in_ready, out_i, out_q, out_valid, level, almost_full, overflow, drop_count
  );

  modport master (
    output in_i, in_q, in_valid, out_ready, clear_overflow,
    input  in_ready, out_i, out_q, out_valid, level, almost_full, overflow, drop_count
  );

endinterface

// File: rtl/ad936x_rx_sample_fifo_sample_ram.sv
// Simple dual-port sample store: synchronous write, asynchronous read.
// Deliberately unreset so it maps onto distributed RAM.
module sample_ram
  import ad936x_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  iq_sample_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output iq_sample_t               rdata
);

  iq_sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ad936x_rx_sample_fifo.sv
// RX sample FIFO behind the AD936x data interface: RAM plus a registered
// first-word-fall-through output stage; overflowing pairs are dropped and counted.
module ad936x_rx_sample_fifo
  import ad936x_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  ad936x_rx_sample_fifo_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(ALMOST_FULL);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_d;
  logic [LVL_W-1:0] ram_cnt;
  logic             in_ready_r;
  logic             out_valid_r;
  iq_sample_t       out_r;
  logic             almost_full_r;
  logic             overflow_r;
  logic [CNT_W-1:0] drop_cnt_r;

  iq_sample_t in_sample;
  iq_sample_t ram_rdata;
  logic       push;
  logic       pop;
  logic       is_full;
  logic       wr;
  logic       drop;
  logic       load;
  logic       from_ram;
  logic       bypass;
  logic       ram_we;

  assign in_sample = '{i: bus.in_i, q: bus.in_q};

  assign push    = bus.in_valid & in_ready_r;
  assign pop     = out_valid_r & bus.out_ready;
  assign is_full = (level_r == FULL_LVL);
  assign wr      = push & (~is_full | pop);
  assign drop    = push & is_full & ~pop;

  // level counts the output register too; the RAM holds whatever is behind it.
  assign ram_cnt  = level_r - {{(LVL_W-1){1'b0}}, out_valid_r};
  assign load     = ~out_valid_r | pop;
  assign from_ram = load & (ram_cnt != '0);
  // An empty RAM lets a new pair go straight into the output register.
  assign bypass   = load & (ram_cnt == '0) & wr;
  assign ram_we   = wr & ~bypass;

  always_comb begin
    level_d = level_r;
    case ({wr, pop})
      2'b10:   level_d = level_r + 1'b1;
      2'b01:   level_d = level_r - 1'b1;
      default: level_d = level_r;
    endcase
  end

  sample_ram #(
    .DEPTH (DEPTH)
  ) u_sample_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (in_sample),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      level_r       <= '0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_r         <= '0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      drop_cnt_r    <= '0;
    end else begin
      in_ready_r    <= 1'b1;
      level_r       <= level_d;
      almost_full_r <= (level_d >= AF_LVL);

      if (ram_we) wptr <= wptr + 1'b1;

      // out_r only changes when a real pair is loaded, so it holds when idle.
      if (from_ram) begin
        out_r       <= ram_rdata;
        rptr        <= rptr + 1'b1;
        out_valid_r <= 1'b1;
      end else if (bypass) begin
        out_r       <= in_sample;
        out_valid_r <= 1'b1;
      end else if (load) begin
        out_valid_r <= 1'b0;
      end

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        overflow_r <= 1'b1;
        if (bus.clear_overflow)  drop_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (~&drop_cnt_r)   drop_cnt_r <= drop_cnt_r + 1'b1;
      end else if (bus.clear_overflow) begin
        overflow_r <= 1'b0;
        drop_cnt_r <= '0;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_i       = out_r.i;
  assign bus.out_q       = out_r.q;
  assign bus.out_valid   = out_valid_r;
  assign bus.level       = level_r;
  assign bus.almost_full = almost_full_r;
  assign bus.overflow    = overflow_r;
  assign bus.drop_count  = drop_cnt_r;

endmodule

// File: tb/tb_ad936x_rx_sample_fifo.sv
// Bench for ad936x_rx_sample_fifo: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the FIFO.
module tb_ad936x_rx_sample_fifo;
  import ad936x_pkg::*;

  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ad936x_rx_sample_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  ad936x_rx_sample_fifo #(
    .DEPTH       (DEPTH),
    .ALMOST_FULL (AF),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          m_drops;
  bit          m_ov;
  bit          m_ready;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input logic [23:0] d, input bit rdy, input bit clr);
    bit pop_m, push_m, full_m, drop_m;
    pop_m  = rdy && (exp_q.size() > 0);
    push_m = v && m_ready;
    full_m = (exp_q.size() == DEPTH);
    drop_m = 1'b0;
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) begin
      if (!full_m || pop_m) exp_q.push_back(d);
      else drop_m = 1'b1;
    end
    if (drop_m) begin
      m_ov = 1'b1;
      if (clr) m_drops = 1;
      else if (m_drops < CNT_MAX) m_drops++;
    end else if (clr) begin
      m_ov    = 1'b0;
      m_drops = 0;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check_eq("in_ready",    32'(bus.in_ready),    32'(m_ready));
    check_eq("level",       32'(bus.level),       32'(sz));
    check_eq("out_valid",   32'(bus.out_valid),   32'(sz > 0));
    check_eq("almost_full", 32'(bus.almost_full), 32'(sz >= AF));
    check_eq("overflow",    32'(bus.overflow),    32'(m_ov));
    check_eq("drop_count",  32'(bus.drop_count),  32'(m_drops));
    if (sz > 0) begin
      check_eq("out_i", 32'(bus.out_i), 32'(exp_q[0][23:12]));
      check_eq("out_q", 32'(bus.out_q), 32'(exp_q[0][11:0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit v, input logic [11:0] i, input logic [11:0] q,
                       input bit rdy, input bit clr);
    @(negedge clk);
    bus.in_valid       = v;
    bus.in_i           = i;
    bus.in_q           = q;
    bus.out_ready      = rdy;
    bus.clear_overflow = clr;
    @(posedge clk);
    #1;
    model_step(v, {i, q}, rdy, clr);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 12'h0, 12'h0, rdy, 1'b0);
  endtask

  task automatic fill_pattern(input int n);
    logic [11:0] n12;
    for (int k = 0; k < n; k++) begin
      n12 = 12'(k);
      cycle(1'b1, n12, ~n12, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    idle(1, 1'b0);
  endtask

  // Raise rst between edges and check outputs clear without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_drops = 0;
    m_ov    = 1'b0;
    m_ready = 1'b0;
    check_outputs();
    check_eq("rst_out_i", 32'(bus.out_i), 32'h0);
    check_eq("rst_out_q", 32'(bus.out_q), 32'h0);
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset_release();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    m_drops  = 0;
    m_ov     = 1'b0;
    m_ready  = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_i           = '0;
    bus.in_q           = '0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;

    #1;
    check_outputs();
    check_eq("rst_out_i", 32'(bus.out_i), 32'h0);
    repeat (2) @(posedge clk);
    reset_release();

    // Three pairs through an empty FIFO with the consumer always ready.
    cycle(1'b1, 12'd1, 12'd2, 1'b1, 1'b0);
    cycle(1'b1, 12'd3, 12'd4, 1'b1, 1'b0);
    cycle(1'b1, 12'd5, 12'd6, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill to DEPTH, then drain back-to-back.
    fill_pattern(DEPTH);
    idle(DEPTH + 2, 1'b1);

    // Fill, three drops, drain; then clear the sticky flag.
    fill_pattern(DEPTH);
    for (int k = 0; k < 3; k++) cycle(1'b1, 12'hABC, 12'h123, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b1);
    cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);

    // Full with simultaneous push and pop: no drop, new pair comes out last.
    fill_pattern(DEPTH);
    cycle(1'b1, 12'h7E5, 12'h1A2, 1'b1, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Drop coinciding with clear, clear alone, then saturate the drop counter.
    fill_pattern(DEPTH);
    cycle(1'b1, 12'h111, 12'h222, 1'b0, 1'b1);
    cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    for (int k = 0; k < CNT_MAX + 4; k++)
      cycle(1'b1, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
    cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    idle(DEPTH + 2, 1'b1);

    // Random traffic in phases of differing consumer speed.
    for (int ph = 0; ph < 8; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
      for (int k = 0; k < 80; k++)
        cycle($urandom_range(0, 99) < 75,
              12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
              $urandom_range(0, 99) < rdy_pct,
              $urandom_range(0, 99) < 3);
    end
    idle(DEPTH + 2, 1'b1);

    // Asynchronous reset mid-stream at level 7, then one fresh pair.
    cycle(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    fill_pattern(7);
    check_eq("pre_rst_level", 32'(bus.level), 32'd7);
    async_reset();
    cycle(1'b1, 12'h5A5, 12'hA5A, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
